// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the miniRISC boot loader.
// Holds the loader FSM encoding, the byte-lane indices and the default address width.
package imem_loader_pkg;

   localparam int IMEM_ADDR_W = 12;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_HI,
      ST_HDR_LO,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } ld_state_e;

   function automatic logic takes_byte(input ld_state_e s);
      return (s == ST_HDR_HI) || (s == ST_HDR_LO) ||
             (s == ST_DATA) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer for the boot loader.
// Lane 0 lands in [31:24]; the fourth byte completes the word combinationally.
import imem_loader_pkg::*;

module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  lane_q;
   logic [23:0] sr_q;

   // Lane counter and storage for the first three bytes of a word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q <= LANE_B0;
         sr_q   <= '0;
      end else if (clr) begin
         lane_q <= LANE_B0;
         sr_q   <= '0;
      end else if (in_valid) begin
         lane_q <= lane_q + 2'd1;
         unique case (lane_q)
            LANE_B0: sr_q[23:16] <= in_byte;
            LANE_B1: sr_q[15:8]  <= in_byte;
            LANE_B2: sr_q[7:0]   <= in_byte;
            LANE_B3: sr_q        <= sr_q;
         endcase
      end
   end

   // Word completes on the byte that fills the last lane
   always_comb begin
      word_valid = in_valid && (lane_q == LANE_B3);
      word       = {sr_q, in_byte};
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer; holds the CPU until the image is in.
// Optional checksum byte and XOR accumulator: define LOADER_CHECKSUM_EN.
import imem_loader_pkg::*;

module imem_loader #(
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   ld_state_e       state_q;
   ld_state_e       state_d;
   logic            acc;
   logic [7:0]      cnt_hi_q;
   logic [31:0]     n_full;
   logic            n_ovf;
   logic            n_zero;
   logic [ADDR_W:0] n_q;
   logic [ADDR_W:0] word_cnt_q;
   logic            last_word;
   logic            word_valid;
   logic [31:0]     word;

   localparam logic [31:0] CAP = 32'd1 << ADDR_W;

   assign acc       = byte_valid && byte_ready;
   assign n_full    = {16'd0, cnt_hi_q, byte_data};
   assign n_ovf     = n_full > CAP;
   assign n_zero    = n_full == 32'd0;
   assign last_word = (word_cnt_q + (ADDR_W+1)'(1)) == n_q;
   assign mem_addr  = word_cnt_q[ADDR_W-1:0];

`ifdef LOADER_CHECKSUM_EN
   localparam ld_state_e LAST_ST = ST_CHK;

   logic [7:0] xor_q;
   logic       chk_ok;

   assign chk_ok = byte_data == xor_q;

   // Running XOR of every accepted byte before the checksum itself
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         xor_q <= '0;
      else if (acc && state_q != ST_CHK)
         xor_q <= xor_q ^ byte_data;
   end
`else
   localparam ld_state_e LAST_ST = ST_DONE;
`endif

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (state_q == ST_HDR_HI),
      .in_valid   (acc && state_q == ST_DATA),
      .in_byte    (byte_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic; the last word moves on with its fourth byte
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   state_d = ST_HDR_HI;
         ST_HDR_HI: if (acc) state_d = ST_HDR_LO;
         ST_HDR_LO: begin
            if (acc) begin
               if (n_ovf)       state_d = ST_ERR;
               else if (n_zero) state_d = LAST_ST;
               else             state_d = ST_DATA;
            end
         end
         ST_DATA:   if (word_valid && last_word) state_d = LAST_ST;
`ifdef LOADER_CHECKSUM_EN
         ST_CHK:    if (acc) state_d = chk_ok ? ST_DONE : ST_ERR;
`else
         ST_CHK:    state_d = ST_ERR;
`endif
         ST_DONE:   state_d = ST_DONE;
         ST_ERR:    state_d = ST_ERR;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      cpu_hold  = 1'b1;
      load_done = 1'b0;
      load_err  = 1'b0;
      unique case (1'b1)
         state_q == ST_DONE: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
         end
         state_q == ST_ERR: load_err = 1'b1;
         default: ;
      endcase
   end

   // Registered ready: one idle cycle after reset, drops with the terminal byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         byte_ready <= 1'b0;
      else
         byte_ready <= (state_q != ST_IDLE) && takes_byte(state_d);
   end

   // Header capture: high count byte, then the full count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_hi_q <= '0;
         n_q      <= '0;
      end else if (acc) begin
         if (state_q == ST_HDR_HI) cnt_hi_q <= byte_data;
         if (state_q == ST_HDR_LO) n_q <= n_full[ADDR_W:0];
      end
   end

   // Write port: one-cycle strobe, address advances after the strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         word_cnt_q <= '0;
      end else begin
         mem_we <= word_valid;
         if (word_valid) mem_wdata <= word;
         if (state_q == ST_HDR_HI)
            word_cnt_q <= '0;
         else if (mem_we)
            word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a 16-word memory.
// Stream bytes and expected writes come from directed vectors.
module tb_imem_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] img[$];
   logic [7:0]  csum = 8'h00;
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_wr = -1;
   bit          gap_chk = 1'b0;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe pops one expected write
   always @(negedge clk) begin
      if (rst && mem_we) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h want none",
                     mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.addr));
            check("wr_data", mem_wdata, e.data);
            if (gap_chk && last_wr >= 0)
               check("wr_gap", cyc - last_wr, 4);
         end
         last_wr = cyc;
      end
   end

   // Called at a falling edge; checks async reset values and ready latency
   task automatic do_reset();
      rst = 1'b0;
      byte_valid = 1'b0;
      #1;
      check("rst_ready", 32'(byte_ready), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_done", 32'(load_done), 0);
      check("rst_err", 32'(load_err), 0);
      check("rst_hold", 32'(cpu_hold), 1);
      check("rst_pending", exp_q.size(), 0);
      csum = 8'h00;
      last_wr = -1;
      gap_chk = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_1clk", 32'(byte_ready), 0);
      @(negedge clk);
      check("ready_after_2clk", 32'(byte_ready), 1);
   endtask

   // Offer one byte from a falling edge; returns at the edge after acceptance
   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_timeout: byte %h not accepted in 20 cycles", b);
      end else begin
         csum = csum ^ b;
         @(negedge clk);
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, 32'(load_done), 1);
      check({tag, "_hold"}, 32'(cpu_hold), 0);
      check({tag, "_ready"}, 32'(byte_ready), 0);
      check({tag, "_err"}, 32'(load_err), 0);
   endtask

   task automatic check_err(input string tag);
      check({tag, "_err"}, 32'(load_err), 1);
      check({tag, "_hold"}, 32'(cpu_hold), 1);
      check({tag, "_ready"}, 32'(byte_ready), 0);
      check({tag, "_done"}, 32'(load_done), 0);
   endtask

   // Send header, img[0..n-1] and (when built) the checksum
   task automatic send_image(input int n);
      logic [7:0] c;
      send(8'(n >> 8));
      send(8'(n));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({AW'(i), img[i]});
         send(img[i][31:24]);
         send(img[i][23:16]);
         send(img[i][15:8]);
         send(img[i][7:0]);
      end
`ifdef LOADER_CHECKSUM_EN
      c = csum;
      send(c);
`endif
   endtask

   task automatic finish_test(input string tag);
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bad_chk;
      @(negedge clk);

      // One word
      do_reset();
      img = {32'h2001_0005};
      send_image(1);
      check_done("one");
      finish_test("one");

      // Empty image
      do_reset();
      send_image(0);
      check_done("empty");
      finish_test("empty");

      // Bad checksum: true XOR is 01, stream carries 00
      do_reset();
      exp_q.push_back({AW'(0), 32'hAABB_CCDD});
      send(8'h00);
      send(8'h01);
      send(8'hAA);
      send(8'hBB);
      send(8'hCC);
      send(8'hDD);
`ifdef LOADER_CHECKSUM_EN
      bad_chk = 8'h00;
      send(bad_chk);
      check_err("badchk");
      repeat (4) @(negedge clk);
      check("badchk_ready_hold", 32'(byte_ready), 0);
`else
      bad_chk = 8'h00;
      byte_data = bad_chk;
      check_done("badchk_nochk");
`endif
      finish_test("badchk");

      // Count overflow: 17 words into a 16-word memory
      do_reset();
      send(8'h00);
      send(8'h11);
      check_err("ovf");
      byte_data = 8'h55;
      repeat (6) @(negedge clk);
      check("ovf_ready_hold", 32'(byte_ready), 0);
      check("ovf_err_hold", 32'(load_err), 1);
      finish_test("ovf");

      // Full fill, back to back
      do_reset();
      img = {};
      for (int i = 0; i < 16; i++)
         img.push_back({8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i * 3)});
      gap_chk = 1'b1;
      send_image(16);
      check_done("fill");
      finish_test("fill");
      check("fill_addr_wrap", 32'(mem_addr), 0);

      // Reset after two payload bytes, then reload
      do_reset();
      send(8'h00);
      send(8'h02);
      send(8'h01);
      send(8'h02);
      do_reset();
      img = {32'hDEAD_BEEF};
      send_image(1);
      check_done("reload");
      finish_test("reload");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
